// File: rtl/obstacle_spawner.sv
// Scrolling obstacle field: fixed slot pool shifted on scroll ticks, LFSR-driven respawn
// with difficulty-scaled gap, and a registered per-pixel hit/type lookup for the renderer.
module obstacle_spawner #(
    parameter int          N_SLOTS = 5,
    parameter int          X_W     = 11,
    parameter int          STEP    = 5,
    parameter int          OBJ_W   = 32,
    parameter int          SPAWN_X = 750,
    parameter int          TYPE_W  = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                               clk_rand,
    input  logic                               reset,
    input  logic                               shift_tick,
    input  logic                               start,
    input  logic                               freeze,
    input  logic [15:0]                        score,
    input  logic [9:0]                         px,
    output logic                               obj_hit,
    output logic [TYPE_W-1:0]                  obj_type,
    output logic [$clog2(N_SLOTS+1)-1:0]       active_cnt,
    output logic                               spawn_pulse,
    output logic                               frozen
);

    localparam int              CNT_W     = $clog2(N_SLOTS + 1);
    localparam logic [15:0]     SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [X_W-1:0]  STEP_X    = X_W'(STEP);
    localparam logic [X_W-1:0]  SPAWN_X_X = X_W'(SPAWN_X);
    localparam logic [X_W:0]    OBJW_X    = (X_W + 1)'(OBJ_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_tick;

    logic [X_W-1:0]      r_x    [N_SLOTS];
    logic [TYPE_W-1:0]   r_type [N_SLOTS];
    logic [N_SLOTS-1:0]  r_act;
    logic [X_W-1:0]      r_furthest;
    logic [7:0]          r_range_cur;
    logic [15:0]         r_lfsr;
    logic                r_spawn_pulse;
    logic                r_hit;
    logic [TYPE_W-1:0]   r_obj_type;

    logic [X_W-1:0]      w_x_sh [N_SLOTS];
    logic [N_SLOTS-1:0]  w_act_sh;
    logic [N_SLOTS-1:0]  w_free_oh;
    logic                w_free_found;
    logic [X_W-1:0]      w_furthest_sh;
    logic [15:0]         w_gap_min;
    logic [15:0]         w_thresh;
    logic                w_spawn;
    logic [15:0]         w_prod;
    logic [X_W-1:0]      w_spawn_x;
    logic [15:0]         w_lfsr_nxt;
    logic [X_W:0]        w_px_ext;
    logic [X_W:0]        w_lo;
    logic [X_W:0]        w_hi;
    logic                w_hit;
    logic [TYPE_W-1:0]   w_hit_type;
    logic [CNT_W-1:0]    w_cnt;

    always_ff @(posedge clk_rand) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Freeze outranks the scroll tick, so a simultaneous tick is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (freeze) w_state_nxt = S_FROZEN;
                else        w_tick      = shift_tick;
            end
            default: w_state_nxt = S_FROZEN;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (r_x[i] >= STEP_X) begin
                w_x_sh[i]   = r_x[i] - STEP_X;
                w_act_sh[i] = r_act[i];
            end else begin
                w_x_sh[i]   = r_x[i];
                w_act_sh[i] = 1'b0;
            end
        end
    end

    // Free slot is judged after the shift, so a slot expiring this tick can be reused.
    always_comb begin
        w_free_found = 1'b0;
        w_free_oh    = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!w_act_sh[i] && !w_free_found) begin
                w_free_oh[i] = 1'b1;
                w_free_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_furthest_sh = (r_furthest >= STEP_X) ? (r_furthest - STEP_X) : '0;
        w_gap_min     = (score < 16'd280) ? (16'd400 - score) : 16'd120;
        w_thresh      = 16'd640 - w_gap_min;
        w_spawn       = w_tick && w_free_found && (16'(w_furthest_sh) <= w_thresh);
        w_prod        = r_lfsr[7:0] * r_range_cur;
        w_spawn_x     = X_W'(16'd640 + {8'd0, w_prod[15:8]});
        w_lfsr_nxt    = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    end

    always_ff @(posedge clk_rand) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                r_x[i]    <= (i == 0) ? SPAWN_X_X : '0;
                r_type[i] <= '0;
            end
            r_act         <= N_SLOTS'(1);
            r_furthest    <= SPAWN_X_X;
            r_range_cur   <= 8'd150;
            r_lfsr        <= SEED_EFF;
            r_spawn_pulse <= 1'b0;
        end else begin
            r_lfsr        <= w_lfsr_nxt;
            r_spawn_pulse <= w_spawn;
            if (w_tick) begin
                for (int unsigned i = 0; i < N_SLOTS; i++) begin
                    if (w_spawn && w_free_oh[i]) begin
                        r_x[i]    <= w_spawn_x;
                        r_act[i]  <= 1'b1;
                        r_type[i] <= r_lfsr[8 +: TYPE_W];
                    end else begin
                        r_x[i]   <= w_x_sh[i];
                        r_act[i] <= w_act_sh[i];
                    end
                end
                r_furthest <= w_spawn ? w_spawn_x : w_furthest_sh;
                if (w_spawn && (r_range_cur > 8'd30)) r_range_cur <= r_range_cur - 8'd1;
            end
        end
    end

    always_comb begin
        w_px_ext   = (X_W + 1)'(px);
        w_lo       = '0;
        w_hi       = '0;
        w_hit      = 1'b0;
        w_hit_type = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            w_lo = {1'b0, r_x[i]};
            w_hi = w_lo + OBJW_X;
            if (r_act[i] && !w_hit && (w_px_ext >= w_lo) && (w_px_ext < w_hi)) begin
                w_hit      = 1'b1;
                w_hit_type = r_type[i];
            end
        end
    end

    always_ff @(posedge clk_rand) begin
        if (reset) begin
            r_hit      <= 1'b0;
            r_obj_type <= '0;
        end else begin
            r_hit      <= w_hit;
            r_obj_type <= w_hit_type;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) w_cnt = w_cnt + CNT_W'(r_act[i]);
    end

    assign obj_hit     = r_hit;
    assign obj_type    = r_obj_type;
    assign active_cnt  = w_cnt;
    assign spawn_pulse = r_spawn_pulse;
    assign frozen      = (r_state == S_FROZEN);

endmodule
